// File: rtl/pipe_ctrl_regs.sv
// Control pipeline registers ID->EXE->MEM->WB for the 5-stage CPU.
// Provides E/M-stage hazard feedback plus saturating stall/retire counters.
module pipe_ctrl_regs #(
    parameter int CNT_W    = 32,
    parameter int LINK_REG = 31
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wpcir,
    input  logic             d_wreg,
    input  logic             d_m2reg,
    input  logic             d_wmem,
    input  logic             d_jal,
    input  logic             d_regrt,
    input  logic             d_aluimm,
    input  logic             d_shift,
    input  logic [3:0]       d_aluc,
    input  logic [4:0]       d_rt,
    input  logic [4:0]       d_rd,
    output logic             ewreg,
    output logic             em2reg,
    output logic             ewmem,
    output logic             ejal,
    output logic             ealuimm,
    output logic             eshift,
    output logic [3:0]       ealuc,
    output logic [4:0]       ern,
    output logic             mwreg,
    output logic             mm2reg,
    output logic             mwmem,
    output logic [4:0]       mrn,
    output logic             wwreg,
    output logic             wm2reg,
    output logic [4:0]       wrn,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    logic [4:0] w_d_rn;
    logic [4:0] w_e_rn;

    logic             r_ewreg, r_em2reg, r_ewmem, r_ejal, r_ealuimm, r_eshift, r_e_valid;
    logic [3:0]       r_ealuc;
    logic [4:0]       r_ern;
    logic             r_mwreg, r_mm2reg, r_mwmem, r_m_valid;
    logic [4:0]       r_mrn;
    logic             r_wwreg, r_wm2reg, r_w_valid;
    logic [4:0]       r_wrn;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_retire_cnt;

    assign w_d_rn = d_jal ? 5'(LINK_REG) : (d_regrt ? d_rt : d_rd);
    // Non-writing instructions carry rn=0 so the hazard logic never matches them.
    assign w_e_rn = d_wreg ? w_d_rn : 5'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ewreg      <= 1'b0;
            r_em2reg     <= 1'b0;
            r_ewmem      <= 1'b0;
            r_ejal       <= 1'b0;
            r_ealuimm    <= 1'b0;
            r_eshift     <= 1'b0;
            r_ealuc      <= 4'd0;
            r_ern        <= 5'd0;
            r_e_valid    <= 1'b0;
            r_mwreg      <= 1'b0;
            r_mm2reg     <= 1'b0;
            r_mwmem      <= 1'b0;
            r_mrn        <= 5'd0;
            r_m_valid    <= 1'b0;
            r_wwreg      <= 1'b0;
            r_wm2reg     <= 1'b0;
            r_wrn        <= 5'd0;
            r_w_valid    <= 1'b0;
            r_stall_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            // A stall forces a full bubble regardless of what ID presents.
            r_ewreg   <= wpcir & d_wreg;
            r_em2reg  <= wpcir & d_m2reg;
            r_ewmem   <= wpcir & d_wmem;
            r_ejal    <= wpcir & d_jal;
            r_ealuimm <= wpcir & d_aluimm;
            r_eshift  <= wpcir & d_shift;
            r_ealuc   <= wpcir ? d_aluc : 4'd0;
            r_ern     <= wpcir ? w_e_rn : 5'd0;
            r_e_valid <= wpcir;

            r_mwreg   <= r_ewreg;
            r_mm2reg  <= r_em2reg;
            r_mwmem   <= r_ewmem;
            r_mrn     <= r_ern;
            r_m_valid <= r_e_valid;

            r_wwreg   <= r_mwreg;
            r_wm2reg  <= r_mm2reg;
            r_wrn     <= r_mrn;
            r_w_valid <= r_m_valid;

            if (!wpcir && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (r_w_valid && (r_retire_cnt != {CNT_W{1'b1}}))
                r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign ewreg      = r_ewreg;
    assign em2reg     = r_em2reg;
    assign ewmem      = r_ewmem;
    assign ejal       = r_ejal;
    assign ealuimm    = r_ealuimm;
    assign eshift     = r_eshift;
    assign ealuc      = r_ealuc;
    assign ern        = r_ern;
    assign mwreg      = r_mwreg;
    assign mm2reg     = r_mm2reg;
    assign mwmem      = r_mwmem;
    assign mrn        = r_mrn;
    assign wwreg      = r_wwreg;
    assign wm2reg     = r_wm2reg;
    assign wrn        = r_wrn;
    assign stall_cnt  = r_stall_cnt;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: doc/pipe_ctrl_regs.md
Name: pipe_ctrl_regs

Overview:
- Pipeline-register chain that carries ID-stage control decisions through the EXE, MEM and WB stages of the 5-stage pipelined computer.
- Its E- and M-stage outputs (ewreg/em2reg/ern, mwreg/mm2reg/mrn) are the return half of the hazard interface. The ID control unit consumes them for forwarding selection and load-use stall generation.
- Inserts a bubble into EXE whenever the control unit deasserts wpcir.
- Keeps stall and retire counters for performance debug.

Parameters:
- CNT_W, 32, width of the stall_cnt and retire_cnt counters.
- LINK_REG, 31, destination register number used by jal.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- wpcir  in  1  PC/IR write enable from the ID control unit; 0 = load-use stall, inject a bubble into EXE.
- d_wreg  in  1  ID-stage register-write enable.
- d_m2reg  in  1  ID-stage load select.
- d_wmem  in  1  ID-stage memory write.
- d_jal  in  1  ID-stage jal.
- d_regrt  in  1  1 = destination is rt; 0 = destination is rd.
- d_aluimm  in  1  ALU B operand is the immediate.
- d_shift  in  1  ALU A operand is the shift amount.
- d_aluc  in  4  ALU op.
- d_rt  in  5  rt field.
- d_rd  in  5  rd field.
- ewreg, em2reg, ewmem, ejal, ealuimm, eshift  out  1 each  EXE-stage control.
- ealuc  out  4  EXE ALU op.
- ern  out  5  EXE destination register.
- mwreg, mm2reg, mwmem  out  1 each  MEM-stage control.
- mrn  out  5  MEM destination register.
- wwreg, wm2reg  out  1 each  WB-stage control.
- wrn  out  5  WB destination register.
- stall_cnt  out  CNT_W  count of stall cycles.
- retire_cnt  out  CNT_W  count of instructions reaching WB.

Behaviour:
- Destination select (combinational):
  - d_rn = LINK_REG if d_jal.
  - Otherwise d_rt if d_regrt.
  - Otherwise d_rd.
- Captured E-stage destination = d_wreg ? d_rn : 0. A non-writing instruction therefore always carries rn=0 down the pipe.
- Reset (reset=1 at posedge) clears every output and internal bit to 0: all control bits, ern/mrn/wrn, stall_cnt, retire_cnt, valid bits.
  - Reset overrides all other activity, including mid-stall and mid-pipeline.
  - Instructions in flight are discarded.
- Per posedge with reset=0:
  - EXE stage:
    - wpcir=1: capture all d_* controls and the masked destination; set e_valid=1.
    - wpcir=0 (bubble): ewreg=em2reg=ewmem=ejal=ealuimm=eshift=0, ealuc=0, ern=0, e_valid=0. This holds regardless of the d_* values; the block does not rely on the control unit having gated wreg/wmem.
  - MEM stage: unconditionally captures EXE.
    - mwreg<=ewreg, mm2reg<=em2reg, mwmem<=ewmem, mrn<=ern, m_valid<=e_valid.
  - WB stage: unconditionally captures MEM.
    - wwreg<=mwreg, wm2reg<=mm2reg, wrn<=mrn, w_valid<=m_valid.
- Latency: an instruction sampled at edge n appears on E outputs after edge n, on M after n+1, and on W after n+2.
- stall_cnt: increments by 1 on each edge where wpcir=0. It saturates at all-ones and never wraps.
- retire_cnt: increments by 1 on each edge where w_valid=1, counting the instruction currently in WB. It saturates at all-ones.
- Simultaneous events:
  - A stall edge and a retire edge both update their counters in the same cycle.
  - A stall does not freeze MEM or WB; older instructions drain normally.
- Consecutive stalls inject one bubble per stalled cycle.
- No flush input exists: branches are delayed.
- Outputs are registers only. No combinational path from any input to any output.

Test Plan:
- Reset: hold reset=1 for 2 cycles with d_wreg=1, wpcir=1 -> all outputs 0. After release, the first instruction appears on E one edge later.
- add, d_rd=5, d_regrt=0, wpcir=1, then idle (wreg=0) -> ern=5/ewreg=1, then mrn=5/mwreg=1, then wrn=5/wwreg=1 on successive cycles. retire_cnt reaches 1 one edge after WB.
- lw, d_rt=8, d_regrt=1, d_m2reg=1 -> em2reg=1, ern=8, then mm2reg=1, mrn=8. Jal -> ern=31 regardless of rt/rd. sw, d_wreg=0 -> ern=0, ewmem=1, then mwmem=1.
- wpcir=0 for 1 cycle while d_wreg=1, d_rd=9 -> E holds a bubble (all 0, ern=0). The prior instruction still advances to M. stall_cnt=1. retire_cnt does not count the bubble.
- Back-to-back 3 stall cycles, then 4 valid instructions -> stall_cnt=3. retire_cnt=4 after the last retires.
- Assert reset while the pipe is full and stall_cnt=7 -> everything 0 after the edge.
- With CNT_W=4, 20 stall cycles -> stall_cnt saturates at 15.
